// File: rtl/cc_pkg.sv
// Shared constants, FSM state type and frame-layout helper for the C&C stream receiver.
package cc_pkg;
   localparam int CLOCK_S_W          = 4;
   localparam int OC_W               = 7;
   localparam int DEFAULT_FRAME_BITS = 59;

   typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_SHIFT, ST_COMMIT} cc_state_t;

   typedef enum logic [2:0] {
      FLD_PTT, FLD_ADDR, FLD_FREQ, FLD_CLOCK_S, FLD_OC, FLD_MODE
   } cc_field_t;

   // Offset of a field's MSB from the first (earliest-sent) bit of the frame.
   function automatic int field_offset(input cc_field_t fld, input int addr_w, input int freq_w);
      int off;
      off = 0;
      case (fld)
         FLD_PTT:     off = 0;
         FLD_ADDR:    off = 1;
         FLD_FREQ:    off = 1 + addr_w;
         FLD_CLOCK_S: off = 1 + addr_w + freq_w;
         FLD_OC:      off = 1 + addr_w + freq_w + CLOCK_S_W;
         FLD_MODE:    off = 1 + addr_w + freq_w + CLOCK_S_W + OC_W;
         default:     off = 0;
      endcase
      return off;
   endfunction
endpackage

// File: rtl/cc_edge_sync.sv
// Two-flop synchroniser for an asynchronous input, with registered rise/fall strobes.
module cc_edge_sync (
   input  logic clock,
   input  logic nRST,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [1:0] sync_reg;
   logic       prev_reg;

   always_ff @(posedge clock or negedge nRST) begin
      if (!nRST) begin
         sync_reg <= 2'b00;
         prev_reg <= 1'b0;
         rise     <= 1'b0;
         fall     <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], din};
         prev_reg <= sync_reg[1];
         rise     <= sync_reg[1] & ~prev_reg;
         fall     <= ~sync_reg[1] & prev_reg;
      end
   end

   assign level = sync_reg[1];
endmodule

// File: rtl/cc_stream_rx.sv
// Command & Control serial receiver: deserialises one frame per CLRCLK period and
// commits PTT, clock select, OC, mode and per-receiver frequencies.
module cc_stream_rx
   import cc_pkg::*;
#(
   parameter int FRAME_BITS   = DEFAULT_FRAME_BITS,
   parameter int ADDR_W       = 4,
   parameter int FREQ_W       = 32,
   parameter int NUM_RX       = 4,
   parameter int SKIP_EDGES   = 1,
   parameter int MATCH_FRAMES = 2
) (
   input  logic                     clock,
   input  logic                     nRST,
   input  logic                     CBCLK,
   input  logic                     CLRCLK,
   input  logic                     CC,
   output logic                     ptt,
   output logic [CLOCK_S_W-1:0]     clock_s,
   output logic [OC_W-1:0]          oc,
   output logic                     mode,
   output logic [NUM_RX*FREQ_W-1:0] freq,
   output logic [NUM_RX-1:0]        freq_update,
   output logic                     frame_valid,
   output logic [7:0]               short_count,
   output logic [7:0]               bad_addr_count
);
   localparam int PTT_POS  = FRAME_BITS - 1;
   localparam int ADDR_MSB = FRAME_BITS - 1 - field_offset(FLD_ADDR, ADDR_W, FREQ_W);
   localparam int FREQ_MSB = FRAME_BITS - 1 - field_offset(FLD_FREQ, ADDR_W, FREQ_W);
   localparam int CS_MSB   = FRAME_BITS - 1 - field_offset(FLD_CLOCK_S, ADDR_W, FREQ_W);
   localparam int OC_MSB   = FRAME_BITS - 1 - field_offset(FLD_OC, ADDR_W, FREQ_W);
   localparam int MODE_POS = FRAME_BITS - 1 - field_offset(FLD_MODE, ADDR_W, FREQ_W);
   localparam logic [5:0]      LAST_BIT   = 6'(FRAME_BITS - 1);
   localparam logic [7:0]      LAST_SKIP  = 8'(SKIP_EDGES - 1);
   localparam logic [ADDR_W:0] NUM_RX_EXT = (ADDR_W + 1)'(NUM_RX);
   // With no edges to skip the frame start goes straight to SHIFT.
   localparam cc_state_t START_STATE = (SKIP_EDGES == 0) ? ST_SHIFT : ST_SKIP;

   logic cb_rise, cb_fall_unused, cb_level_unused;
   logic clr_fall, clr_rise_unused, clr_level_unused;
   logic cc_level, cc_rise_unused, cc_fall_unused;

   cc_edge_sync u_sync_cbclk (.clock(clock), .nRST(nRST), .din(CBCLK),
      .level(cb_level_unused), .rise(cb_rise), .fall(cb_fall_unused));
   cc_edge_sync u_sync_clrclk (.clock(clock), .nRST(nRST), .din(CLRCLK),
      .level(clr_level_unused), .rise(clr_rise_unused), .fall(clr_fall));
   cc_edge_sync u_sync_cc (.clock(clock), .nRST(nRST), .din(CC),
      .level(cc_level), .rise(cc_rise_unused), .fall(cc_fall_unused));

   cc_state_t               state_reg, state_next;
   logic [5:0]              bit_cnt_reg;
   logic [7:0]              skip_cnt_reg;
   logic [FRAME_BITS-1:0]   shift_reg;
   logic                    start_frame, short_evt, skip_inc, shift_en;
   logic                    cand_valid_reg;
   logic [ADDR_W-1:0]       cand_addr_reg;
   logic [FREQ_W-1:0]       cand_freq_reg;
   logic                    frame_unused;

   always_ff @(posedge clock or negedge nRST) begin
      if (!nRST) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   // A CLRCLK fall always wins over a CBCLK rise seen in the same cycle.
   always_comb begin
      state_next  = state_reg;
      start_frame = 1'b0;
      short_evt   = 1'b0;
      skip_inc    = 1'b0;
      shift_en    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (clr_fall) begin
               state_next  = START_STATE;
               start_frame = 1'b1;
            end
         end
         ST_SKIP: begin
            if (clr_fall) begin
               state_next  = START_STATE;
               start_frame = 1'b1;
               short_evt   = 1'b1;
            end else if (cb_rise) begin
               skip_inc = 1'b1;
               if (skip_cnt_reg == LAST_SKIP) state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (clr_fall) begin
               state_next  = START_STATE;
               start_frame = 1'b1;
               short_evt   = 1'b1;
            end else if (cb_rise) begin
               shift_en = 1'b1;
               if (bit_cnt_reg == LAST_BIT) state_next = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            state_next = ST_IDLE;
            if (clr_fall) begin
               state_next  = START_STATE;
               start_frame = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nRST) begin
      if (!nRST) begin
         bit_cnt_reg  <= '0;
         skip_cnt_reg <= '0;
         shift_reg    <= '0;
      end else if (start_frame) begin
         bit_cnt_reg  <= '0;
         skip_cnt_reg <= '0;
         shift_reg    <= '0;
      end else begin
         if (skip_inc) skip_cnt_reg <= skip_cnt_reg + 8'd1;
         if (shift_en) begin
            shift_reg   <= {shift_reg[FRAME_BITS-2:0], cc_level};
            bit_cnt_reg <= bit_cnt_reg + 6'd1;
         end
      end
   end

   logic              commit, addr_bad, cand_match, freq_wr;
   logic [ADDR_W-1:0] frm_addr;
   logic [FREQ_W-1:0] frm_freq;

   assign commit       = (state_reg == ST_COMMIT);
   assign frm_addr     = shift_reg[ADDR_MSB -: ADDR_W];
   assign frm_freq     = shift_reg[FREQ_MSB -: FREQ_W];
   assign addr_bad     = ({1'b0, frm_addr} >= NUM_RX_EXT);
   assign cand_match   = cand_valid_reg && (cand_addr_reg == frm_addr) && (cand_freq_reg == frm_freq);
   assign freq_wr      = commit && !addr_bad && ((MATCH_FRAMES == 1) || cand_match);
   assign frame_unused = ^shift_reg;

   always_ff @(posedge clock or negedge nRST) begin
      if (!nRST) begin
         ptt            <= 1'b0;
         clock_s        <= '0;
         oc             <= '0;
         mode           <= 1'b0;
         frame_valid    <= 1'b0;
         short_count    <= '0;
         bad_addr_count <= '0;
         cand_valid_reg <= 1'b0;
         cand_addr_reg  <= '0;
         cand_freq_reg  <= '0;
      end else begin
         frame_valid <= commit;
         if (commit) begin
            ptt     <= shift_reg[PTT_POS];
            clock_s <= shift_reg[CS_MSB -: CLOCK_S_W];
            oc      <= shift_reg[OC_MSB -: OC_W];
            mode    <= shift_reg[MODE_POS];
            if (addr_bad && bad_addr_count != 8'hFF) bad_addr_count <= bad_addr_count + 8'd1;
         end
         if (short_evt && short_count != 8'hFF) short_count <= short_count + 8'd1;
         if (short_evt || (commit && addr_bad)) begin
            cand_valid_reg <= 1'b0;
         end else if (commit) begin
            cand_valid_reg <= 1'b1;
            cand_addr_reg  <= frm_addr;
            cand_freq_reg  <= frm_freq;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_RX; gi++) begin : g_rx
         logic [FREQ_W-1:0] freq_reg;
         logic              upd_reg;
         always_ff @(posedge clock or negedge nRST) begin
            if (!nRST) begin
               freq_reg <= '0;
               upd_reg  <= 1'b0;
            end else begin
               upd_reg <= 1'b0;
               if (freq_wr && frm_addr == ADDR_W'(gi)) begin
                  freq_reg <= frm_freq;
                  upd_reg  <= (freq_reg != frm_freq);
               end
            end
         end
         assign freq[gi*FREQ_W +: FREQ_W] = freq_reg;
         assign freq_update[gi]           = upd_reg;
      end
   endgenerate
endmodule

// File: tb/tb_cc_stream_rx.sv
// Directed bench for cc_stream_rx: table of full frames plus short-frame, reset and saturation sequences.
module tb_cc_stream_rx;
   localparam int HALF = 160;
   localparam logic [31:0] F2 = 32'h00D6_D8A0;
   localparam logic [31:0] F1 = 32'd7_000_001;
   localparam logic [31:0] F3 = 32'h0BAD_F00D;

   logic         clock = 1'b0;
   logic         nRST, CBCLK, CLRCLK, CC;
   logic         ptt, mode, frame_valid;
   logic [3:0]   clock_s;
   logic [6:0]   oc;
   logic [127:0] freq;
   logic [3:0]   freq_update;
   logic [7:0]   short_count, bad_addr_count;

   int checks = 0;
   int errors = 0;
   int fv_cnt = 0;
   int fu_tot = 0;

   cc_stream_rx #(
      .FRAME_BITS(59), .ADDR_W(4), .FREQ_W(32), .NUM_RX(4), .SKIP_EDGES(1), .MATCH_FRAMES(2)
   ) dut (
      .clock(clock), .nRST(nRST), .CBCLK(CBCLK), .CLRCLK(CLRCLK), .CC(CC),
      .ptt(ptt), .clock_s(clock_s), .oc(oc), .mode(mode), .freq(freq),
      .freq_update(freq_update), .frame_valid(frame_valid),
      .short_count(short_count), .bad_addr_count(bad_addr_count)
   );

   always #10 clock = ~clock;

   always @(negedge clock) begin
      fv_cnt <= fv_cnt + int'(frame_valid);
      fu_tot <= fu_tot + $countones(freq_update);
   end

   typedef struct {
      logic         p;
      logic [3:0]   a;
      logic [31:0]  f;
      logic [3:0]   cs;
      logic [6:0]   o;
      logic         m;
      logic [127:0] ef;
      int           efu;
      int           ebad;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [58:0] mk_frame(input logic p, input logic [3:0] a, input logic [31:0] f,
                                            input logic [3:0] cs, input logic [6:0] o, input logic m);
      return {p, a, f, cs, o, m, 10'b0};
   endfunction

   task automatic cb_cycle(input logic bitv);
      CBCLK = 1'b0;
      CC    = bitv;
      #HALF;
      CBCLK = 1'b1;
      #HALF;
   endtask

   // CLRCLK falls with CBCLK; one rising edge is skipped, then nbits CBCLK periods follow.
   task automatic send_frame(input logic [58:0] fr, input int nbits);
      CBCLK  = 1'b0;
      CLRCLK = 1'b0;
      CC     = 1'b0;
      #HALF;
      CBCLK = 1'b1;
      #HALF;
      CLRCLK = 1'b1;
      for (int i = 0; i < nbits; i++) cb_cycle((i < 59) ? fr[58 - i] : 1'b0);
   endtask

   task automatic check_fields(input string tag, input logic p, input logic [3:0] cs,
                               input logic [6:0] o, input logic m);
      chk({tag, " ptt"}, ptt, p);
      chk({tag, " clock_s"}, clock_s, cs);
      chk({tag, " oc"}, oc, o);
      chk({tag, " mode"}, mode, m);
   endtask

   initial begin
      int fv0, fu0;
      vecs[0] = '{1'b1, 4'd2, F2, 4'hA, 7'h55, 1'b1, 128'h0, 0, 0};
      vecs[1] = '{1'b1, 4'd2, F2, 4'hA, 7'h55, 1'b1, {32'h0, F2, 32'h0, 32'h0}, 1, 0};
      vecs[2] = '{1'b1, 4'd2, F2, 4'hA, 7'h55, 1'b1, {32'h0, F2, 32'h0, 32'h0}, 0, 0};
      vecs[3] = '{1'b0, 4'd1, 32'd7_000_000, 4'h3, 7'h2A, 1'b0, {32'h0, F2, 32'h0, 32'h0}, 0, 0};
      vecs[4] = '{1'b1, 4'd1, F1, 4'h5, 7'h11, 1'b1, {32'h0, F2, 32'h0, 32'h0}, 0, 0};
      vecs[5] = '{1'b0, 4'd1, F1, 4'h6, 7'h22, 1'b0, {32'h0, F2, F1, 32'h0}, 1, 0};
      vecs[6] = '{1'b1, 4'd3, F3, 4'h7, 7'h33, 1'b1, {32'h0, F2, F1, 32'h0}, 0, 0};
      vecs[7] = '{1'b0, 4'hF, 32'h1234_5678, 4'hC, 7'h7F, 1'b0, {32'h0, F2, F1, 32'h0}, 0, 1};
      vecs[8] = '{1'b1, 4'd3, F3, 4'h8, 7'h44, 1'b0, {32'h0, F2, F1, 32'h0}, 0, 1};
      vecs[9] = '{1'b0, 4'd3, F3, 4'h9, 7'h0F, 1'b1, {F3, F2, F1, 32'h0}, 1, 1};

      nRST = 1'b0; CBCLK = 1'b0; CLRCLK = 1'b1; CC = 1'b0;
      #200;
      chk("reset ptt", ptt, 1'b0);
      chk("reset oc", oc, 7'h0);
      chk("reset freq", freq, 128'h0);
      chk("reset counters", {short_count, bad_addr_count}, 16'h0);
      nRST = 1'b1;
      #200;

      for (int v = 0; v < 10; v++) begin
         fv0 = fv_cnt;
         fu0 = fu_tot;
         send_frame(mk_frame(vecs[v].p, vecs[v].a, vecs[v].f, vecs[v].cs, vecs[v].o, vecs[v].m), 63);
         $display("frame %0d addr=%0h freq=%0h -> freq=%0h bad=%0d", v, vecs[v].a, vecs[v].f, freq, bad_addr_count);
         check_fields($sformatf("v%0d", v), vecs[v].p, vecs[v].cs, vecs[v].o, vecs[v].m);
         chk($sformatf("v%0d freq", v), freq, vecs[v].ef);
         chk($sformatf("v%0d freq_update pulses", v), fu_tot - fu0, vecs[v].efu);
         chk($sformatf("v%0d frame_valid pulses", v), fv_cnt - fv0, 1);
         chk($sformatf("v%0d bad_addr_count", v), bad_addr_count, vecs[v].ebad);
         chk($sformatf("v%0d short_count", v), short_count, 8'd0);
      end

      // Short frame: discards the partial frame and invalidates the candidate.
      send_frame(mk_frame(1'b0, 4'd0, 32'h55, 4'h1, 7'h01, 1'b0), 63);
      $display("short seq: candidate frame addr=0 freq=55");
      fv0 = fv_cnt;
      send_frame(mk_frame(1'b1, 4'd0, 32'h55, 4'h2, 7'h02, 1'b1), 30);
      $display("short seq: 30-bit frame sent");
      chk("short no frame_valid", fv_cnt - fv0, 0);
      send_frame(mk_frame(1'b1, 4'd0, 32'h55, 4'h6, 7'h33, 1'b1), 63);
      $display("short seq: full frame after short, short_count=%0d", short_count);
      chk("short short_count", short_count, 8'd1);
      chk("short next frame_valid", fv_cnt - fv0, 1);
      check_fields("short next", 1'b1, 4'h6, 7'h33, 1'b1);
      chk("short freq0 held", freq[31:0], 32'h0);
      fu0 = fu_tot;
      send_frame(mk_frame(1'b0, 4'd0, 32'h55, 4'h6, 7'h33, 1'b0), 63);
      $display("short seq: confirm frame, freq0=%0h", freq[31:0]);
      chk("short freq0 written", freq[31:0], 32'h55);
      chk("short freq_update", fu_tot - fu0, 1);

      // Reset in the middle of a frame.
      send_frame(mk_frame(1'b1, 4'd2, 32'h1234, 4'hF, 7'h7F, 1'b1), 20);
      nRST = 1'b0;
      #1;
      $display("reset seq: nRST asserted at bit 20");
      chk("midreset ptt/mode", {ptt, mode}, 2'b00);
      chk("midreset clock_s/oc", {clock_s, oc}, 11'h0);
      chk("midreset freq", freq, 128'h0);
      chk("midreset counters", {short_count, bad_addr_count}, 16'h0);
      chk("midreset pulses", {frame_valid, freq_update}, 5'h0);
      #199;
      nRST = 1'b1;
      #200;
      fv0 = fv_cnt;
      send_frame(mk_frame(1'b1, 4'd2, 32'hCAFE_0001, 4'h9, 7'h6C, 1'b1), 63);
      $display("reset seq: first frame after release");
      check_fields("post-reset", 1'b1, 4'h9, 7'h6C, 1'b1);
      chk("post-reset frame_valid", fv_cnt - fv0, 1);
      chk("post-reset short_count", short_count, 8'd0);
      chk("post-reset freq2 held", freq[95:64], 32'h0);
      send_frame(mk_frame(1'b1, 4'd2, 32'hCAFE_0001, 4'h9, 7'h6C, 1'b1), 63);
      $display("reset seq: second frame, freq2=%0h", freq[95:64]);
      chk("post-reset freq2", freq[95:64], 32'hCAFE_0001);

      // Saturation: 300 short frames, each counted when the following frame starts.
      for (int s = 0; s < 300; s++) begin
         send_frame(mk_frame(1'b0, 4'd0, 32'h0, 4'h0, 7'h0, 1'b0), 5);
         $display("sat seq: short frame %0d", s);
      end
      fv0 = fv_cnt;
      send_frame(mk_frame(1'b0, 4'd1, 32'h0, 4'h3, 7'h05, 1'b0), 63);
      $display("sat seq: closing frame, short_count=%0d", short_count);
      chk("sat short_count", short_count, 8'd255);
      chk("sat frame_valid", fv_cnt - fv0, 1);
      check_fields("sat", 1'b0, 4'h3, 7'h05, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cc_stream_rx.md
# cc_stream_rx

Parametrised Command & Control receiver for the Atlas C20 serial stream on Mercury. It replaces the fixed single-receiver C&C decoder. The block oversamples CBCLK, CLRCLK and CC in the system clock domain and deserialises one frame per CLRCLK period, MSB first. It then commits PTT, clock select, OC, mode and a per-receiver NCO frequency to registered outputs, filtering out short frames and bad addresses.

## Interface
Parameters:
- FRAME_BITS, 59: bits shifted per frame. Must be ≥ 1+ADDR_W+FREQ_W+12 and ≤ 63.
- ADDR_W, 4: address field width.
- FREQ_W, 32: frequency field width (Hz).
- NUM_RX, 4: number of frequency registers (1..2^ADDR_W).
- SKIP_EDGES, 1: CBCLK rising edges ignored after the CLRCLK fall.
- MATCH_FRAMES, 2: identical consecutive frames needed before a frequency commits (1 or 2).

Ports:
- clock, in, 1: system clock, ≥ 4× CBCLK.
- nRST, in, 1: asynchronous active-low reset.
- CBCLK, in, 1: C&C bit clock; asynchronous to clock.
- CLRCLK, in, 1: frame strobe; asynchronous to clock.
- CC, in, 1: serial data; changes on CBCLK falling edges.
- ptt, out, 1: push-to-talk.
- clock_s, out, 4: clock source select.
- oc, out, 7: open-collector outputs.
- mode, out, 1: mode bit.
- freq, out, NUM_RX*FREQ_W: frequency registers; receiver n occupies bits [n*FREQ_W +: FREQ_W].
- freq_update, out, NUM_RX: one-cycle pulse when freq[n] changes.
- frame_valid, out, 1: one-cycle pulse per accepted frame.
- short_count, out, 8: saturating count of truncated frames.
- bad_addr_count, out, 8: saturating count of frames with address ≥ NUM_RX.

## Operation
- **Input sync.** CBCLK, CLRCLK and CC each pass through a 2-flop synchroniser. Edges are detected on the synchronised CBCLK and CLRCLK.
- **Frame layout, MSB first:** PTT(1), ADDR(ADDR_W), FREQ(FREQ_W), CLOCK_S(4), OC(7), MODE(1). Any remaining bits up to FRAME_BITS are padding and are ignored.
- **State machine:**
  - IDLE: on a CLRCLK falling edge, go to SKIP, clear the bit counter and shift register.
  - SKIP: count CBCLK rising edges. After SKIP_EDGES of them, go to SHIFT. With SKIP_EDGES=0, SKIP is bypassed and the same rising edge is taken by SHIFT.
  - SHIFT: on each CBCLK rising edge, shift in the synchronised CC. When the bit count reaches FRAME_BITS, go to COMMIT.
  - COMMIT: lasts one cycle, then returns to IDLE.
- **Short frame.** A CLRCLK falling edge while in SKIP or SHIFT:
  - increment short_count;
  - discard the partial frame;
  - restart in SKIP (the edge is the new frame's start).
- **COMMIT actions:**
  - Update ptt, clock_s, oc and mode unconditionally, and pulse frame_valid.
  - If ADDR ≥ NUM_RX, increment bad_addr_count and leave freq unchanged.
  - Otherwise, with MATCH_FRAMES=2, store {ADDR, FREQ} as the candidate. Write freq[ADDR] only when the candidate equals the previous frame's candidate.
  - With MATCH_FRAMES=1, write freq[ADDR] directly.
  - Pulse freq_update[ADDR] only when the written value differs from the stored value.
- **Candidate invalidation.** The previous-frame candidate is invalidated by a short frame or a bad address.
- **Counters** saturate at 255 and do not wrap.
- **Reset** (nRST low) is asynchronous:
  - every output, counter, candidate, synchroniser and the shift register go to 0;
  - the FSM returns to IDLE.
  - Reset asserted mid-frame discards the frame. After release, decoding waits for the next CLRCLK falling edge.

## Timing
- Input-to-detected-edge latency is 3 clock cycles: 2 synchroniser stages plus the edge register.
- Outputs update and pulses assert on the clock cycle after COMMIT. Pulses are exactly 1 cycle wide.
- Latency from the last frame bit's CBCLK rising edge to the outputs is 5 clock cycles.
- CC is sampled at the synchronised CBCLK rise. CC is stable for half a CBCLK period, so with clock ≥ 4× CBCLK the sample is safe.
- If a CLRCLK fall and a CBCLK rise are detected in the same cycle, the CLRCLK fall wins. That CBCLK edge is not counted.
- A CLRCLK fall in the COMMIT cycle is not lost: it is registered and the FSM enters SKIP immediately after COMMIT.

## Structure
- Package cc_pkg:
  - field-width constants (CLOCK_S_W=4, OC_W=7);
  - a function giving the MSB offset of each field from ADDR_W and FREQ_W;
  - default FRAME_BITS.
- Sub-module cc_edge_sync:
  - 2-flop synchroniser with registered rise and fall outputs;
  - three instances (CBCLK, CLRCLK, CC); the CC instance uses only its level output.

## Test plan
- **Nominal frame.** Stimulus: CBCLK 3.072 MHz, frame period 64 CBCLK, clock 48 MHz, MATCH_FRAMES=2. Frame PTT=1, ADDR=2, FREQ=0x00D6_D8A0, CLOCK_S=4'hA, OC=7'h55, MODE=1, sent twice. Required response:
  - ptt, clock_s, oc and mode valid after frame 1;
  - freq[2]=0x00D6_D8A0 and one freq_update[2] pulse after frame 2;
  - freq_update does not pulse on a third identical frame.
- **Glitch filter.** Stimulus: ADDR=1, FREQ=7_000_000, then ADDR=1, FREQ=7_000_001, then FREQ=7_000_001 again. Required response: freq[1] stays 0 after frames 1 and 2, and becomes 7_000_001 after frame 3.
- **Short frame.** Stimulus: CLRCLK falls after 30 bits. Required response: short_count=1, no frame_valid pulse, and the next full frame decodes correctly.
- **Bad address.** Stimulus: ADDR=4'hF with NUM_RX=4. Required response: bad_addr_count=1, all freq unchanged, oc updated.
- **Reset.** Stimulus: nRST asserted at bit 20 of a frame. Required response: all outputs 0 immediately; the next full frame decodes correctly after release.
- **Saturation.** Stimulus: 300 short frames. Required response: short_count=255.
